// File: rtl/trap_sequencer_if.sv
// Trap sequencer bus: encoder/CPU inputs and the trap-entry outputs back to them.
// The master drives the pending mask and CPU status; the slave is the sequencer.
interface trap_sequencer_if #(
  parameter int PC_W = 16
);
  logic [7:0]      trapnr;
  logic            ie;
  logic            instr_done;
  logic            reti;
  logic [PC_W-1:0] pc;
  logic            deassert;
  logic            trap_take;
  logic [2:0]      cause;
  logic [PC_W-1:0] vector;
  logic [PC_W-1:0] epc;
  logic            in_trap;
  logic            double_fault;

  modport master (
    output trapnr, ie, instr_done, reti, pc,
    input  deassert, trap_take, cause, vector, epc, in_trap, double_fault
  );

  modport slave (
    input  trapnr, ie, instr_done, reti, pc,
    output deassert, trap_take, cause, vector, epc, in_trap, double_fault
  );
endinterface

// File: rtl/trap_sequencer.sv
// Picks the highest-priority eligible trap at an instruction boundary; deassert same cycle,
// trap_take one cycle later. No backpressure: CPU strobes reti to return, faults in a handler halt.
module trap_sequencer #(
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] VEC_BASE  = 16'h0100,
  parameter int              VEC_SHIFT = 3
) (
  input logic           clk,
  input logic           reset,
  trap_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    HANDLER = 2'd2,
    DFAULT  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      cause_q;
  logic [PC_W-1:0] epc_q;
  logic            double_fault_q;
  logic [2:0]      prio;
  logic            fault_pend;
  logic            eligible;
  logic            take;
  logic [PC_W-1:0] cause_ext;

  assign fault_pend = |bus.trapnr[1:0];
  assign eligible   = fault_pend | (|bus.trapnr[7:2] & bus.ie);

  // Lowest set bit wins; it is the same bit the encoder clears on deassert.
  always_comb begin
    prio = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (bus.trapnr[i]) prio = 3'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.instr_done && eligible) begin
          take      = 1'b1;
          state_nxt = TAKE;
        end
      end
      TAKE:    state_nxt = HANDLER;
      HANDLER: begin
        if (bus.reti)                          state_nxt = IDLE;
        else if (bus.instr_done && fault_pend) state_nxt = DFAULT;
      end
      DFAULT:  state_nxt = DFAULT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cause_q        <= 3'd0;
      epc_q          <= '0;
      double_fault_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        cause_q <= prio;
        epc_q   <= bus.pc;
      end
      if (state_nxt == DFAULT) double_fault_q <= 1'b1;
    end
  end

  assign cause_ext        = PC_W'(cause_q);
  assign bus.deassert     = take & ~reset;
  assign bus.trap_take    = (state == TAKE);
  assign bus.in_trap      = (state != IDLE);
  assign bus.cause        = cause_q;
  assign bus.epc          = epc_q;
  assign bus.vector       = VEC_BASE + (cause_ext << VEC_SHIFT);
  assign bus.double_fault = double_fault_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer; the bench plays the encoder by clearing the
// deasserted bit itself after each entry edge.
module tb_trap_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  trap_sequencer_if #(.PC_W(16)) bus ();

  trap_sequencer #(.PC_W(16), .VEC_BASE(16'h0100), .VEC_SHIFT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".trap_take"},    32'(bus.trap_take),    32'd0);
    chk({tag, ".in_trap"},      32'(bus.in_trap),      32'd0);
    chk({tag, ".cause"},        32'(bus.cause),        32'd0);
    chk({tag, ".epc"},          32'(bus.epc),          32'h0);
    chk({tag, ".vector"},       32'(bus.vector),       32'h0100);
    chk({tag, ".double_fault"}, 32'(bus.double_fault), 32'd0);
    chk({tag, ".deassert"},     32'(bus.deassert),     32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.trapnr = 8'h00; bus.ie = 1'b0; bus.instr_done = 1'b0;
    bus.reti = 1'b0;    bus.pc = 16'h0000;
    step(); step();
    chk_reset_vals("rst");

    // Irq at bit 2 with bit 5 also pending; bit 2 wins.
    reset = 1'b0;
    bus.trapnr = 8'b0010_0100; bus.ie = 1'b1; bus.instr_done = 1'b1; bus.pc = 16'h0042;
    #1 chk("t1.deassert", 32'(bus.deassert), 32'd1);
    step();
    bus.trapnr = 8'b0010_0000; bus.instr_done = 1'b0;
    #1;
    chk("t1.trap_take", 32'(bus.trap_take), 32'd1);
    chk("t1.cause",     32'(bus.cause),     32'd2);
    chk("t1.vector",    32'(bus.vector),    32'h0110);
    chk("t1.epc",       32'(bus.epc),       32'h0042);
    chk("t1.in_trap",   32'(bus.in_trap),   32'd1);
    chk("t1.deassert_take", 32'(bus.deassert), 32'd0);
    step();
    bus.instr_done = 1'b1;
    #1;
    chk("t1.handler_take", 32'(bus.trap_take), 32'd0);
    chk("t1.handler_in",   32'(bus.in_trap),   32'd1);
    chk("t1.handler_noclr", 32'(bus.deassert), 32'd0);
    bus.instr_done = 1'b0; bus.reti = 1'b1;
    step();
    bus.reti = 1'b0; bus.trapnr = 8'h00;
    #1 chk("t1.idle_after_reti", 32'(bus.in_trap), 32'd0);

    // Masked irq stays pending until ie rises.
    bus.trapnr = 8'b0000_1000; bus.ie = 1'b0; bus.instr_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 chk("t2.masked_deassert", 32'(bus.deassert), 32'd0);
      step();
      chk("t2.masked_in_trap", 32'(bus.in_trap), 32'd0);
    end
    bus.ie = 1'b1;
    #1 chk("t2.ie_deassert", 32'(bus.deassert), 32'd1);
    step();
    bus.trapnr = 8'h00; bus.instr_done = 1'b0;
    #1;
    chk("t2.trap_take", 32'(bus.trap_take), 32'd1);
    chk("t2.cause",     32'(bus.cause),     32'd3);
    chk("t2.vector",    32'(bus.vector),    32'h0118);
    step();
    bus.reti = 1'b1;
    step();
    bus.reti = 1'b0;

    // Fault is taken with ie=0; masked irq alone is not.
    bus.trapnr = 8'b0001_0000; bus.ie = 1'b0; bus.instr_done = 1'b1;
    #1 chk("t3.irq_only_deassert", 32'(bus.deassert), 32'd0);
    step();
    chk("t3.irq_only_in_trap", 32'(bus.in_trap), 32'd0);
    bus.trapnr = 8'b0001_0010;
    #1 chk("t3.fault_deassert", 32'(bus.deassert), 32'd1);
    step();
    bus.trapnr = 8'b0001_0000; bus.instr_done = 1'b0;
    #1;
    chk("t3.trap_take", 32'(bus.trap_take), 32'd1);
    chk("t3.cause",     32'(bus.cause),     32'd1);
    chk("t3.vector",    32'(bus.vector),    32'h0108);
    step();

    // Fault in handler: double fault, sticky until reset.
    bus.trapnr = 8'b0001_0001; bus.instr_done = 1'b1;
    #1 chk("t4.no_deassert", 32'(bus.deassert), 32'd0);
    step();
    chk("t4.double_fault", 32'(bus.double_fault), 32'd1);
    chk("t4.in_trap",      32'(bus.in_trap),      32'd1);
    chk("t4.deassert",     32'(bus.deassert),     32'd0);
    bus.reti = 1'b1;
    step(); step();
    chk("t4.df_sticky", 32'(bus.double_fault), 32'd1);
    chk("t4.df_in_trap", 32'(bus.in_trap),     32'd1);
    chk("t4.df_deassert", 32'(bus.deassert),   32'd0);
    reset = 1'b1; bus.reti = 1'b0; bus.instr_done = 1'b0; bus.trapnr = 8'h00;
    step();
    chk_reset_vals("t4.rst");
    reset = 1'b0;

    // reti beats a simultaneous fault; the fault is taken from IDLE next.
    bus.trapnr = 8'b0000_0100; bus.ie = 1'b1; bus.instr_done = 1'b1; bus.pc = 16'h0200;
    step();
    bus.trapnr = 8'h00; bus.instr_done = 1'b0;
    step();
    bus.reti = 1'b1; bus.trapnr = 8'b0000_0001; bus.instr_done = 1'b1;
    step();
    bus.reti = 1'b0;
    #1;
    chk("t5.idle",         32'(bus.in_trap),      32'd0);
    chk("t5.no_df",        32'(bus.double_fault), 32'd0);
    chk("t5.deassert",     32'(bus.deassert),     32'd1);
    step();
    bus.trapnr = 8'h00; bus.instr_done = 1'b0;
    #1;
    chk("t5.trap_take", 32'(bus.trap_take),    32'd1);
    chk("t5.cause",     32'(bus.cause),        32'd0);
    chk("t5.vector",    32'(bus.vector),       32'h0100);
    chk("t5.epc",       32'(bus.epc),          32'h0200);
    chk("t5.df",        32'(bus.double_fault), 32'd0);
    step();
    bus.reti = 1'b1;
    step();
    bus.reti = 1'b0;

    // Reset during the TAKE cycle.
    bus.trapnr = 8'b0000_0010; bus.ie = 1'b0; bus.instr_done = 1'b1; bus.pc = 16'h1234;
    step();
    bus.trapnr = 8'h00; bus.instr_done = 1'b0;
    #1;
    chk("t6.trap_take", 32'(bus.trap_take), 32'd1);
    chk("t6.epc",       32'(bus.epc),       32'h1234);
    reset = 1'b1;
    step();
    chk("t6.rst_take",  32'(bus.trap_take), 32'd0);
    chk("t6.rst_in",    32'(bus.in_trap),   32'd0);
    chk("t6.rst_epc",   32'(bus.epc),       32'h0);
    chk("t6.rst_cause", 32'(bus.cause),     32'd0);
    reset = 1'b0;
    step();
    chk("t6.stay_idle", 32'(bus.in_trap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Consumer side of the interrupt priority encoder. It watches the pending-trap bitmask, waits for an instruction boundary, and selects the highest-priority eligible trap. In the same cycle it pulses `deassert` so the encoder clears exactly that bit. It then hands the CPU a one-cycle trap-entry strobe with cause, handler vector and saved PC, and holds off further interrupts until return-from-trap.

## Interface
- `PC_W`, 16, width of `pc`, `epc`, `vector`
- `VEC_BASE`, 16'h0100, handler table base address
- `VEC_SHIFT`, 3, log2 of handler slot size in bytes
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `trapnr`  in  8  pending-trap bitmask from encoder; bit 0 has highest priority
- `ie`  in  1  interrupt-enable bit from control register; masks irq-class causes only
- `instr_done`  in  1  CPU is at an instruction boundary this cycle
- `reti`  in  1  return-from-trap strobe from CPU
- `pc`  in  PC_W  PC of next instruction to execute
- `deassert`  out  1  clear highest-priority pending bit in encoder (combinational)
- `trap_take`  out  1  one-cycle pulse: CPU loads `vector` into PC
- `cause`  out  3  index of trap being serviced
- `vector`  out  PC_W  handler address, VEC_BASE + (cause << VEC_SHIFT), modulo 2^PC_W
- `epc`  out  PC_W  PC saved at trap entry
- `in_trap`  out  1  handler executing
- `double_fault`  out  1  sticky: fault raised while in handler; CPU halts

## Operation
- Cause classes:
  - fault class = `trapnr[1:0]`, never masked
  - irq class = `trapnr[7:2]`, masked by `ie`
- `eligible` = `|trapnr[1:0]` | (`|trapnr[7:2]` & `ie`)
- `prio` = index of the lowest set bit of `trapnr`. This is the same bit the encoder clears on `deassert`.
- FSM states: IDLE, TAKE, HANDLER, DFAULT.
- IDLE
  - When `instr_done` & `eligible`:
    - `deassert`=1 combinationally
    - on the clock edge: `cause`<=`prio`, `epc`<=`pc`, go to TAKE
  - Otherwise stay in IDLE. `reti` is ignored.
- TAKE (exactly 1 cycle): `trap_take`=1, `in_trap`=1, go to HANDLER.
- HANDLER: `in_trap`=1. New traps accumulate in the encoder and no `deassert` is issued.
  - `reti`=1: go to IDLE. `reti` wins over a simultaneous fault; that fault stays pending and is taken from IDLE at the next `instr_done`.
  - Else `instr_done` & `|trapnr[1:0]`: go to DFAULT with `double_fault`<=1.
- DFAULT: `in_trap`=1, `double_fault`=1. Stays until `reset`; all inputs ignored.
- `cause` and `epc` hold their values until the next entry to TAKE.
- `vector` is combinational from `cause`; the shift is zero-extended and the add wraps at PC_W.

## Timing
- Reset values: state IDLE, `cause`=0, `epc`=0, `vector`=VEC_BASE, `trap_take`=0, `in_trap`=0, `double_fault`=0, `deassert`=0.
- `reset` takes priority over every transition, including mid-TAKE or in DFAULT; the next cycle is IDLE.
- Trap entry timeline:
  - cycle N (instr_done & eligible in IDLE): `deassert` high
  - cycle N+1: `trap_take` high, `cause`/`vector`/`epc` valid, encoder bit already cleared
  - cycle N+2 onward: HANDLER
- `deassert` must be generated in the same cycle `prio` is sampled. A higher-priority bit arriving at edge N then cannot cause a mismatched clear.
- `deassert` is high for exactly one cycle per trap entry and never outside IDLE.
- Minimum back-to-back service: `reti` at cycle M, IDLE at M+1, next `deassert` at M+1 if `instr_done` & `eligible`.
- An irq pending with `ie`=0 stays in the encoder untouched; it is taken at the first `instr_done` after `ie` rises.

## Test plan
- `trapnr`=8'b0010_0100, `ie`=1, `instr_done` pulse, `pc`=16'h0042
  - `deassert` high in that cycle
  - next cycle: `trap_take`=1, `cause`=2, `vector`=16'h0110, `epc`=16'h0042
- `trapnr`=8'b0000_1000, `ie`=0, `instr_done` held high for 10 cycles
  - no `deassert`, stays in IDLE
  - raise `ie`: `cause`=3, `vector`=16'h0118
- `trapnr`=8'b0001_0000, `ie`=0, `instr_done`
  - none of the pending bits is a fault, so no trap is taken
  - set `trapnr`=8'b0001_0010: `cause`=1, `vector`=16'h0108, even with `ie`=0
- In HANDLER, fault bit 0 appears with `instr_done`=1 and `reti`=0
  - `double_fault`=1 and stays 1; `deassert` stays 0
  - `reset` returns all outputs to reset values
- In HANDLER, `reti` and fault bit 0 in the same cycle
  - go to IDLE
  - next `instr_done`: `cause`=0, `vector`=16'h0100, `double_fault`=0
- Assert `reset` during the TAKE cycle
  - next cycle: `trap_take`=0, `in_trap`=0, `epc`=0, `cause`=0
